// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the stopwatch seven-segment display path.
package seven_seg_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Level that switches a common-anode digit off (anode lines are active-low).
  localparam logic ANODE_OFF = 1'b1;

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Slot/digit timebase for the display scan. It holds the slot counter and the
// digit index. Besides the current-cycle flags it also gives a one-cycle
// lookahead, so the top can register outputs that match the cycle they
// describe.
module scan_timer #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_nxt,
  output logic             slot_end,
  output logic             frame_end,
  output logic             in_blank,
  output logic             blank_nxt,
  output logic             frame_end_nxt
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Current-cycle flags and the counter values for the coming cycle.
  always_comb begin
    slot_end      = (cnt == CNT_LAST);
    frame_end     = slot_end && (idx == IDX_LAST);
    in_blank      = (cnt < CNT_BLANK);
    cnt_nxt       = slot_end ? '0 : cnt + 1'b1;
    idx_nxt       = idx;
    if (slot_end) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    blank_nxt     = (cnt_nxt < CNT_BLANK);
    frame_end_nxt = (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
  end

  // Counter registers; the digit index only moves when the slot wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller that time-multiplexes one seven_seg_decoder across the
// stopwatch digits. It owns the BLANK/DRIVE sequencing, the tear-free shadow
// copy of the digits, leading-zero blanking and the update handshake. Every
// output is registered from next-cycle values, so each output describes the
// cycle in which it is visible.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lzb_en,
  input  logic                    upd_req,
  output logic                    upd_ack,
  output logic [3:0]              dec_code,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nxt;
  logic                    slot_end;
  logic                    frame_end;
  logic                    in_blank;
  logic                    blank_nxt;
  logic                    frame_end_nxt;

  scan_state_t             state;
  scan_state_t             state_nxt;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] shadow_nxt;
  logic                    pending;
  logic                    pending_nxt;
  logic                    load;
  logic                    all_zero;
  logic                    lz_blank;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic                    dp_nxt;
  digit_t                  code_nxt;

  scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .IDX_W        (IDX_W)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .idx           (idx),
    .idx_nxt       (idx_nxt),
    .slot_end      (slot_end),
    .frame_end     (frame_end),
    .in_blank      (in_blank),
    .blank_nxt     (blank_nxt),
    .frame_end_nxt (frame_end_nxt)
  );

  // Slot sequencing: blank the anodes at the start of each slot, then drive.
  always_comb begin
    state_nxt = state;
    case (state)
      BLANK:   if (in_blank && !blank_nxt) state_nxt = DRIVE;
      DRIVE:   if (slot_end) state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase
  end

  // Update handshake: upd_req is a request level that is remembered as
  // pending. A load happens only on the frame-boundary cycle. upd_ack pulses
  // for one cycle right after that load. Any number of requests in one frame
  // give one load. A request in the cycle after a boundary waits for the next
  // frame.
  always_comb begin
    load        = frame_end && (pending || upd_req);
    shadow_nxt  = load ? digits_in : shadow;
    pending_nxt = load ? 1'b0 : (pending || upd_req);
  end

  // Next-cycle display values: nibble select, leading-zero test, anode and DP.
  always_comb begin
    code_nxt = shadow_nxt[{idx_nxt, 2'b00} +: 4];
    all_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(idx_nxt)) && (shadow_nxt[4*j +: 4] != 4'h0)) begin
        all_zero = 1'b0;
      end
    end
    lz_blank = lzb_en && (idx_nxt != '0) && all_zero;
    an_nxt   = {NUM_DIGITS{ANODE_OFF}};
    dp_nxt   = 1'b1;
    if (state_nxt == DRIVE) begin
      dp_nxt = ~dp_mask[idx_nxt];
      if (!lz_blank) begin
        an_nxt[idx_nxt] = ~ANODE_OFF;
      end
    end
  end

  // State, shadow and registered outputs; reset drops any pending request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BLANK;
      shadow     <= '0;
      pending    <= 1'b0;
      upd_ack    <= 1'b0;
      dec_code   <= 4'h0;
      an_n       <= {NUM_DIGITS{ANODE_OFF}};
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shadow     <= shadow_nxt;
      pending    <= pending_nxt;
      upd_ack    <= load;
      dec_code   <= code_nxt;
      an_n       <= an_nxt;
      dp_n       <= dp_nxt;
      frame_done <= frame_end_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8 and
// BLANK_CYCLES=2. Cycle 0 is the cycle in which reset is released. Outputs are
// sampled on falling edges, and inputs change on those same falling edges.
module tb_seven_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]  dp_mask;
  logic          lzb_en;
  logic          upd_req;
  logic          upd_ack;
  logic [3:0]    dec_code;
  logic [N-1:0]  an_n;
  logic          dp_n;
  logic          frame_done;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [3:0] code;
    logic       dp;
    logic       fd;
    logic       ack;
  } vec_t;

  vec_t vq[$];
  int   cyc;
  int   n_total = 0;
  int   n_pass  = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .dp_mask    (dp_mask),
    .lzb_en     (lzb_en),
    .upd_req    (upd_req),
    .upd_ack    (upd_ack),
    .dec_code   (dec_code),
    .an_n       (an_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic do_reset();
    rst       = 1'b1;
    digits_in = '0;
    dp_mask   = '0;
    lzb_en    = 1'b0;
    upd_req   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic add(input int c, input logic [3:0] an, input logic [3:0] code,
                     input logic dp, input logic fd, input logic ack);
    vec_t v;
    v.cyc = c; v.an = an; v.code = code; v.dp = dp; v.fd = fd; v.ack = ack;
    vq.push_back(v);
  endtask

  // Scoreboard: compare every table entry that is due in this cycle.
  task automatic check_cycle(input string name);
    foreach (vq[i]) begin
      if (vq[i].cyc == cyc) begin
        n_total++;
        if (an_n !== vq[i].an || dec_code !== vq[i].code || dp_n !== vq[i].dp ||
            frame_done !== vq[i].fd || upd_ack !== vq[i].ack) begin
          $display("FAIL %s c%0d: got an=%b code=%h dp=%b fd=%b ack=%b, exp an=%b code=%h dp=%b fd=%b ack=%b",
                   name, cyc, an_n, dec_code, dp_n, frame_done, upd_ack,
                   vq[i].an, vq[i].code, vq[i].dp, vq[i].fd, vq[i].ack);
        end else begin
          n_pass++;
        end
      end
    end
  endtask

  // Driver: the inputs each scenario wants in cycle c.
  task automatic apply_stim(input int sc, input int c);
    case (sc)
      2, 6: begin
        digits_in = 16'h1234;
        upd_req   = (c == 5);
      end
      3: begin
        lzb_en    = 1'b1;
        digits_in = (c < 40) ? 16'h0050 : 16'h0000;
        upd_req   = (c == 0) || (c == 40);
      end
      4: begin
        digits_in = (c < 40) ? 16'h00CB : 16'h00F0;
        upd_req   = (c == 31) || (c == 32);
      end
      5: dp_mask = 4'b0100;
      default: upd_req = 1'b0;
    endcase
  endtask

  task automatic run_sc(input int sc, input int last, input string name);
    for (int c = 0; c <= last; c++) begin
      if (c > 0) @(negedge clk);
      cyc = c;
      apply_stim(sc, c);
      check_cycle(name);
    end
  endtask

  initial begin
    // Free-running scan with an empty shadow.
    do_reset();
    vq.delete();
    add(0,  4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(1,  4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(2,  4'b1110, 4'h0, 1'b1, 1'b0, 1'b0);
    add(7,  4'b1110, 4'h0, 1'b1, 1'b0, 1'b0);
    add(8,  4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(10, 4'b1101, 4'h0, 1'b1, 1'b0, 1'b0);
    add(18, 4'b1011, 4'h0, 1'b1, 1'b0, 1'b0);
    add(26, 4'b0111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(30, 4'b0111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(31, 4'b0111, 4'h0, 1'b1, 1'b1, 1'b0);
    add(32, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(34, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b0);
    add(63, 4'b0111, 4'h0, 1'b1, 1'b1, 1'b0);
    run_sc(1, 64, "scan");

    // Load 0x1234 with a request in cycle 5.
    do_reset();
    vq.delete();
    add(30, 4'b0111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(31, 4'b0111, 4'h0, 1'b1, 1'b1, 1'b0);
    add(32, 4'b1111, 4'h4, 1'b1, 1'b0, 1'b1);
    add(33, 4'b1111, 4'h4, 1'b1, 1'b0, 1'b0);
    add(34, 4'b1110, 4'h4, 1'b1, 1'b0, 1'b0);
    add(40, 4'b1111, 4'h3, 1'b1, 1'b0, 1'b0);
    add(42, 4'b1101, 4'h3, 1'b1, 1'b0, 1'b0);
    add(50, 4'b1011, 4'h2, 1'b1, 1'b0, 1'b0);
    add(58, 4'b0111, 4'h1, 1'b1, 1'b0, 1'b0);
    add(63, 4'b0111, 4'h1, 1'b1, 1'b1, 1'b0);
    add(64, 4'b1111, 4'h4, 1'b1, 1'b0, 1'b0);
    run_sc(2, 64, "load");

    // Leading-zero blanking: 0x0050, then 0x0000.
    do_reset();
    vq.delete();
    add(2,  4'b1110, 4'h0, 1'b1, 1'b0, 1'b0);
    add(10, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(32, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
    add(34, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b0);
    add(42, 4'b1101, 4'h5, 1'b1, 1'b0, 1'b0);
    add(50, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(58, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(64, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
    add(66, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b0);
    add(74, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(82, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(90, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    run_sc(3, 90, "lzb");

    // Request held in the boundary cycle and the next cycle: two loads.
    do_reset();
    vq.delete();
    add(2,  4'b1110, 4'h0, 1'b1, 1'b0, 1'b0);
    add(31, 4'b0111, 4'h0, 1'b1, 1'b1, 1'b0);
    add(32, 4'b1111, 4'hB, 1'b1, 1'b0, 1'b1);
    add(33, 4'b1111, 4'hB, 1'b1, 1'b0, 1'b0);
    add(42, 4'b1101, 4'hC, 1'b1, 1'b0, 1'b0);
    add(50, 4'b1011, 4'h0, 1'b1, 1'b0, 1'b0);
    add(63, 4'b0111, 4'h0, 1'b1, 1'b1, 1'b0);
    add(64, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
    add(65, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(74, 4'b1101, 4'hF, 1'b1, 1'b0, 1'b0);
    run_sc(4, 74, "double");

    // Decimal point on digit 2 only.
    do_reset();
    vq.delete();
    add(2,  4'b1110, 4'h0, 1'b1, 1'b0, 1'b0);
    add(42, 4'b1101, 4'h0, 1'b1, 1'b0, 1'b0);
    add(48, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(49, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(50, 4'b1011, 4'h0, 1'b0, 1'b0, 1'b0);
    add(55, 4'b1011, 4'h0, 1'b0, 1'b0, 1'b0);
    add(56, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(58, 4'b0111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(63, 4'b0111, 4'h0, 1'b1, 1'b1, 1'b0);
    run_sc(5, 63, "dp");

    // Reset in the DRIVE part of slot 2 while a request is pending.
    do_reset();
    vq.delete();
    add(20, 4'b1011, 4'h0, 1'b1, 1'b0, 1'b0);
    run_sc(6, 20, "pre_rst");
    rst = 1'b1;
    #1;
    n_total++;
    if (an_n !== 4'b1111 || dp_n !== 1'b1 || dec_code !== 4'h0 ||
        upd_ack !== 1'b0 || frame_done !== 1'b0) begin
      $display("FAIL async_rst: got an=%b dp=%b code=%h ack=%b fd=%b, exp an=1111 dp=1 code=0 ack=0 fd=0",
               an_n, dp_n, dec_code, upd_ack, frame_done);
    end else begin
      n_pass++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    upd_req = 1'b0;
    vq.delete();
    add(2,  4'b1110, 4'h0, 1'b1, 1'b0, 1'b0);
    add(31, 4'b0111, 4'h0, 1'b1, 1'b1, 1'b0);
    add(32, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    add(34, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b0);
    run_sc(0, 40, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
